// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - variable-length code packer with first-word-fall-through output FIFO
module bit_packer #(
    parameter int CODE_W = 16,
    parameter int LEN_W  = 5,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 16,
    parameter int THRESH = DEPTH / 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic [CODE_W-1:0]          in_code,
    input  logic [LEN_W-1:0]           in_len,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W):0]     out_len,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic                       threshold,
    output logic                       len_err
);
    localparam int OLW   = $clog2(OUT_W) + 1;
    localparam int ACC_W = OUT_W + CODE_W;
    localparam int AL_W  = $clog2(ACC_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OUT_W + OLW + 1;

    localparam logic [0:0] ST_PACK  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]        state, state_n;
    logic [ACC_W-1:0]  acc, acc_a, acc_n;
    logic [AL_W-1:0]   acc_len, len_a, len_n;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  wr_entry, head;
    logic [LEN_W-1:0]  eff_len;
    logic [CODE_W-1:0] code_m;
    logic              len_over, accept, word_push, flush_push, push, pop, room;

    assign room     = count < CNT_W'(DEPTH);
    assign in_ready = (state == ST_PACK) && room;
    assign accept   = in_valid && in_ready;
    assign len_over = in_len > LEN_W'(CODE_W);
    assign eff_len  = len_over ? LEN_W'(CODE_W) : in_len;

    always_comb begin
        code_m = '0;
        for (int i = 0; i < CODE_W; i++) begin
            code_m[i] = in_code[i] && (LEN_W'(i) < eff_len);
        end
    end

    // Beat is merged first, then a full word is split off; the flush entry only
    // ever sees what remains, which is how same-edge flush+beat is ordered.
    always_comb begin
        acc_a = acc;
        len_a = acc_len;
        if (accept) begin
            acc_a = acc | (ACC_W'(code_m) << acc_len);
            len_a = acc_len + AL_W'(eff_len);
        end
        word_push  = accept && (len_a >= AL_W'(OUT_W));
        flush_push = (state == ST_FLUSH) && room;
        acc_n = word_push ? (acc_a >> OUT_W) : acc_a;
        len_n = word_push ? (len_a - AL_W'(OUT_W)) : len_a;
        if (flush_push) begin
            acc_n = '0;
            len_n = '0;
        end
        wr_entry = flush_push ? {1'b1, OLW'(acc_len), acc[OUT_W-1:0]}
                              : {1'b0, OLW'(OUT_W), acc_a[OUT_W-1:0]};
        state_n = state;
        if (state == ST_PACK && flush) begin
            state_n = ST_FLUSH;
        end else if (flush_push) begin
            state_n = ST_PACK;
        end
    end

    assign push = word_push || flush_push;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_PACK;
            acc     <= '0;
            acc_len <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            len_err <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            acc_len <= len_n;
            if (accept && len_over) begin
                len_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
    assign out_len   = out_valid ? head[OUT_W +: OLW] : '0;
    assign out_last  = out_valid && head[ENT_W-1];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign threshold = (count >= CNT_W'(THRESH));
endmodule

// File: tb/tb_bit_packer.sv
// tb/tb_bit_packer.sv - directed self-checking bench for bit_packer
module tb_bit_packer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_code = '0;
    logic [4:0]  in_len = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_len;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        full, empty, threshold, len_err;

    int vectors = 0;
    int miscompares = 0;

    bit_packer dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_code(in_code), .in_len(in_len), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_len(out_len), .out_last(out_last),
        .out_ready(out_ready),
        .full(full), .empty(empty), .threshold(threshold), .len_err(len_err)
    );

    always #5 clock = ~clock;

    task automatic send(input logic [15:0] code, input logic [4:0] len, input logic v, input logic fl);
        @(negedge clock);
        in_valid = v;
        in_code  = code;
        in_len   = len;
        flush    = fl;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pop_entry(output logic [31:0] d, output logic [5:0] l, output logic lst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (out_valid) ok = 1'b1;
        end
        d = out_data;
        l = out_len;
        lst = out_last;
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        vectors++;
        if ({out_valid, empty, full, threshold, in_ready, out_last, len_err} !== 7'b0100100) begin
            miscompares++;
            $display("FAIL reset_flags: got v/e/f/t/r/l/err=%b required 0100100",
                     {out_valid, empty, full, threshold, in_ready, out_last, len_err});
        end
        vectors++;
        if (out_data !== 32'h0 || out_len !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%0d required 0/0", out_data, out_len);
        end
    endtask

    task automatic test_aligned();
        logic [31:0] d; logic [5:0] l; logic lst; bit ok;
        send(16'h11, 5'd8, 1'b1, 1'b0);
        send(16'h22, 5'd8, 1'b1, 1'b0);
        send(16'h33, 5'd8, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL aligned_partial: out_valid=%b required 0", out_valid);
        end
        send(16'h44, 5'd8, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL aligned_latency: out_valid=%b required 1", out_valid);
        end
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h44332211 || l !== 6'd32 || lst !== 1'b0) begin
            miscompares++;
            $display("FAIL aligned_word: ok=%0d got %h/%0d/%b required 44332211/32/0", ok, d, l, lst);
        end
        send(16'h0, 5'd0, 1'b0, 1'b1);
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h0 || l !== 6'd0 || lst !== 1'b1) begin
            miscompares++;
            $display("FAIL aligned_acc_len: ok=%0d got %h/%0d/%b required 0/0/1", ok, d, l, lst);
        end
    endtask

    task automatic test_straddle_flush();
        logic [31:0] d; logic [5:0] l; logic lst; bit ok;
        send(16'hFABC, 5'd12, 1'b1, 1'b0);
        send(16'h0DEF, 5'd12, 1'b1, 1'b0);
        send(16'h5123, 5'd12, 1'b1, 1'b0);
        send(16'h0, 5'd0, 1'b0, 1'b1);
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h23DEFABC || l !== 6'd32 || lst !== 1'b0) begin
            miscompares++;
            $display("FAIL straddle_word: ok=%0d got %h/%0d/%b required 23DEFABC/32/0", ok, d, l, lst);
        end
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h1 || l !== 6'd4 || lst !== 1'b1) begin
            miscompares++;
            $display("FAIL straddle_flush: ok=%0d got %h/%0d/%b required 1/4/1", ok, d, l, lst);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [5:0] l; logic lst; bit ok;
        logic [31:0] exp_w;
        for (int k = 0; k < 16; k++) begin
            send({8'hA0, 8'(k)}, 5'd16, 1'b1, 1'b0);
            send({8'hB0, 8'(k)}, 5'd16, 1'b1, 1'b0);
            vectors++;
            if (threshold !== (k + 1 >= 8) || full !== (k + 1 == 16) || in_ready !== (k + 1 < 16)) begin
                miscompares++;
                $display("FAIL bp_flags count=%0d: got thr/full/rdy=%b%b%b required %b%b%b", k + 1,
                         threshold, full, in_ready, k + 1 >= 8, k + 1 == 16, k + 1 < 16);
            end
        end
        @(negedge clock);
        d = out_data;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_same_cycle_pop: in_ready=%b required 0", in_ready);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_after_pop: in_ready/full=%b%b required 10", in_ready, full);
        end
        vectors++;
        if (d !== 32'hB000A000) begin
            miscompares++;
            $display("FAIL bp_order word 0: got %h required B000A000", d);
        end
        for (int k = 1; k < 16; k++) begin
            pop_entry(d, l, lst, ok);
            exp_w = {8'hB0, 8'(k), 8'hA0, 8'(k)};
            vectors++;
            if (!ok || d !== exp_w || l !== 6'd32 || lst !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_order word %0d: ok=%0d got %h/%0d/%b required %h/32/0", k, ok, d, l, lst, exp_w);
            end
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drained: empty=%b required 1", empty);
        end
    endtask

    task automatic test_empty_flush_same_cycle();
        logic [31:0] d; logic [5:0] l; logic lst; bit ok;
        send(16'h0, 5'd0, 1'b0, 1'b1);
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h0 || l !== 6'd0 || lst !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_flush: ok=%0d got %h/%0d/%b required 0/0/1", ok, d, l, lst);
        end
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_clear: got %b required 0", len_err);
        end
        send(16'hFFFF, 5'd20, 1'b1, 1'b1);
        vectors++;
        if (len_err !== 1'b1) begin
            miscompares++;
            $display("FAIL len_err_set: got %b required 1", len_err);
        end
        pop_entry(d, l, lst, ok);
        vectors++;
        if (!ok || d !== 32'h0000FFFF || l !== 6'd16 || lst !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_flush: ok=%0d got %h/%0d/%b required 0000FFFF/16/1", ok, d, l, lst);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            send(16'h1234, 5'd16, 1'b1, 1'b0);
            send(16'h5678, 5'd16, 1'b1, 1'b0);
        end
        send(16'h00AB, 5'd8, 1'b1, 1'b0);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({out_valid, empty, full, threshold, in_ready} !== 5'b01001 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got v/e/f/t/r=%b data=%h required 01001 data=0",
                     {out_valid, empty, full, threshold, in_ready}, out_data);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0 || len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_discard: out_valid/len_err=%b%b required 00", out_valid, len_err);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_straddle_flush();
        test_backpressure();
        test_empty_flush_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 The parameter CODE_W SHALL default to 16 and SHALL set the maximum code width in bits (1..32).
REQ-002 The parameter LEN_W SHALL default to 5 and SHALL set the in_len width, which must hold the value CODE_W.
REQ-003 The parameter OUT_W SHALL default to 32 and SHALL set the packed output word width (OUT_W >= CODE_W).
REQ-004 The parameter DEPTH SHALL default to 16 and SHALL set the output FIFO entry count (power of 2, >= 2).
REQ-005 The parameter THRESH SHALL default to DEPTH/2 and SHALL set the FIFO occupancy at which threshold asserts.
REQ-006 clock  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-007 resetn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-008 in_valid  in  1  SHALL indicate that a code beat is offered.
REQ-009 in_code  in  CODE_W  SHALL carry the code, LSB-first; bits at or above in_len are ignored.
REQ-010 in_len  in  LEN_W  SHALL carry the code length, 0..CODE_W.
REQ-011 in_ready  out  1  SHALL indicate that the block accepts a beat this cycle.
REQ-012 flush  in  1  SHALL be a single-cycle request to emit the partial word and an end marker.
REQ-013 out_valid  out  1  SHALL indicate that the FIFO head is valid (first-word fall-through).
REQ-014 out_data  out  OUT_W  SHALL carry the packed word at the FIFO head.
REQ-015 out_len  out  clog2(OUT_W)+1  SHALL carry the number of valid bits in out_data.
REQ-016 out_last  out  1  SHALL mark the entry produced by a flush.
REQ-017 out_ready  in  1  SHALL be the consumer pop; a pop occurs when out_valid and out_ready are both high.
REQ-018 full / empty / threshold  out  1 each  SHALL reflect FIFO count == DEPTH / count == 0 / count >= THRESH.
REQ-019 len_err  out  1  SHALL be a sticky flag set when in_len > CODE_W is accepted.

Function
REQ-020 A beat SHALL be accepted on a rising edge only when in_valid and in_ready are both high.
REQ-021 in_ready SHALL equal (state==PACK) and (registered FIFO count < DEPTH); a same-cycle pop SHALL NOT raise in_ready.
REQ-022 An accepted beat SHALL be processed as follows:
  - the masked code (in_code & ((1<<len)-1)) is ORed into the accumulator at bit position acc_len;
  - acc_len becomes acc_len + len.
REQ-023 When acc_len + len >= OUT_W, the same edge SHALL:
  - write accumulator bits [OUT_W-1:0] to the FIFO with out_len=OUT_W and out_last=0;
  - right-shift the accumulator by OUT_W;
  - set acc_len to acc_len + len - OUT_W.
REQ-024 in_len > CODE_W SHALL be treated as CODE_W and SHALL set len_err; in_len = 0 SHALL leave the accumulator unchanged.
REQ-025 The state machine SHALL have two states, PACK and FLUSH:
  - PACK -> FLUSH on any edge with flush=1;
  - FLUSH -> PACK on the edge that writes the flush entry, which requires count < DEPTH.
REQ-026 The flush entry SHALL be: data = accumulator low bits (zero above acc_len), out_len = acc_len, out_last = 1. The accumulator and acc_len SHALL then clear.
REQ-027 A flush with acc_len = 0 SHALL still write an entry with data = 0, len = 0, last = 1.
REQ-028 When flush and an accepted beat occur on the same edge, the beat SHALL be packed first, including any full-word push, and its remainder SHALL go into the flush entry.
REQ-029 flush asserted while already in FLUSH SHALL be ignored.
REQ-030 Latency: a word completed at edge N SHALL appear at the FIFO head after edge N if the FIFO was empty.
REQ-031 Simultaneous push and pop SHALL leave the count unchanged; a pop when empty SHALL NOT occur, because out_valid is low.
REQ-032 The FIFO SHALL preserve entry order and SHALL never overwrite an unread entry.

Reset
REQ-033 resetn low SHALL immediately clear: accumulator, acc_len, FIFO pointers/count, len_err; state = PACK.
REQ-034 During and after reset: out_valid=0, empty=1, full=0, threshold=0, in_ready=1, out_data=0, out_len=0, out_last=0.
REQ-035 Reset mid-operation SHALL discard all buffered and partial data; no flush entry SHALL be produced.

Verification
REQ-036 Reset: assert resetn=0 mid-stream with 3 words queued -> out_valid=0, empty=1, in_ready=1 with no clock edge required.
REQ-037 Aligned: beats 0x11,0x22,0x33,0x44 with len 8 -> one entry 0x44332211, len 32, last 0; acc_len=0.
REQ-038 Straddle and flush: beats 0xABC,0xDEF,0x123 with len 12, then flush -> entries 0x23DEFABC/32/0 and 0x00000001/4/1.
REQ-039 Backpressure: out_ready=0, push 16 words:
  - threshold rises when count reaches 8;
  - full=1 and in_ready=0 at count 16;
  - one pop -> in_ready=1 on the following cycle;
  - all data is read back in order.
REQ-040 Empty flush and same-cycle: flush with acc_len=0 -> entry 0/0/1. Beat 0xFFFF len 20 plus flush on the same edge -> len_err=1, entry 0x0000FFFF/16/1.
